// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_stream_reader
// Brief    : Reads a word range from the 4-bank data memory and streams it
//            out LSB-first as bytes over a valid/ready port.
// Revision : 1.0
// ============================================================================
module mem_stream_reader #(
    parameter int N     = 32,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             mem_re,
    output logic [N-1:0]     mem_addr,
    input  logic [N-1:0]     mem_rd_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [N-1:0]     c_addr_one = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    logic [2:0]       r_state;
    logic [N-1:0]     r_addr;
    logic [CNT_W-1:0] r_rem;
    logic [N-1:0]     r_mem_addr;
    logic [N-1:0]     r_shreg;
    logic [1:0]       r_idx;
    logic             r_err_flag;

    logic             w_bank_ok;
    logic             w_xfer;
    logic [N-1:0]     w_addr_nxt;

    // Banks 0..3 occupy address[17:16]; any higher bit set is out of range.
    assign w_bank_ok  = ~|r_addr[N-1:18];
    assign w_xfer     = (r_state == S_SEND) && out_ready;
    assign w_addr_nxt = r_addr + c_addr_one;

    assign mem_re    = (r_state == S_FETCH) && w_bank_ok;
    assign mem_addr  = r_mem_addr;
    assign out_data  = r_shreg[7:0];
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign err       = (r_state == S_FIN) && r_err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_mem_addr <= '0;
            r_shreg    <= '0;
            r_idx      <= '0;
            r_err_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= base_addr;
                        r_rem  <= word_count;
                        if (word_count == c_cnt_zero) begin
                            r_state <= S_FIN;
                        end else begin
                            r_mem_addr <= base_addr;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_bank_ok) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_err_flag <= 1'b1;
                        r_state    <= S_FIN;
                    end
                end
                S_WAIT: begin
                    r_shreg <= mem_rd_data;
                    r_idx   <= 2'd0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx == 2'd3) begin
                            r_rem  <= r_rem - c_cnt_one;
                            r_addr <= w_addr_nxt;
                            if (r_rem == c_cnt_one) begin
                                r_state <= S_FIN;
                            end else begin
                                r_mem_addr <= w_addr_nxt;
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_shreg <= r_shreg >> 8;
                            r_idx   <= r_idx + 2'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_err_flag <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// Testbench for mem_stream_reader: memory model, byte monitor and
// randomized transfers checked against a word-range reference model.
module tb_mem_stream_reader;

    localparam int N     = 32;
    localparam int CNT_W = 19;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     base_addr;
    logic [CNT_W-1:0] word_count;
    logic             mem_re;
    logic [N-1:0]     mem_addr;
    logic [N-1:0]     mem_rd_data = '0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    mem_stream_reader #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory contents: explicit overrides, otherwise a hash of the address.
    logic [31:0] ovr [logic [31:0]];
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_re === 1'b1) mem_rd_data <= memval(mem_addr);
    end

    logic [7:0]  got_q [$];
    logic [31:0] addr_q [$];
    int done_cnt, err_cnt, err_lone;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
            if (mem_re === 1'b1) addr_q.push_back(mem_addr);
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
            if (err === 1'b1 && done !== 1'b1) err_lone++;
        end
    end

    // Reference model: words base..base+count-1, 4 bytes each LSB first,
    // stopping with an error at the first word at or above 0x40000.
    logic [7:0] exp_q [$];
    bit         exp_err;
    task automatic build_exp(input logic [31:0] base, input int count);
        logic [31:0] a;
        logic [31:0] w;
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < count; i++) begin
            a = base + 32'(i);
            if (a >= 32'h0004_0000) begin
                exp_err = 1'b1;
                break;
            end
            w = memval(a);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    function automatic bit stream_ok();
        if (got_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        err_lone = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL wait_done: no done after %0d cycles, required done within budget", budget);
        end
        tick();
    endtask

    task automatic run_xfer(input logic [31:0] base, input int count, input bit rnd);
        build_exp(base, count);
        clear_mon();
        base_addr  = base;
        word_count = CNT_W'(count);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        wait_done(10);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_re, mem_addr, out_data, out_valid, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: re=%b addr=%h data=%h v=%b busy=%b done=%b err=%b, required all 0",
                     mem_re, mem_addr, out_data, out_valid, busy, done, err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] eb [4];
        eb = '{8'h44, 8'h33, 8'h22, 8'h11};
        ovr[32'h10] = 32'h1122_3344;
        clear_mon();
        base_addr = 32'h10; word_count = 1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL single_fetch: busy=%b re=%b addr=%h, required 1 1 00000010", busy, mem_re, mem_addr);
        end
        tick();
        checks++;
        if (mem_re !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: re=%b v=%b busy=%b, required 0 0 1", mem_re, out_valid, busy);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== eb[b] || done !== 1'b0) begin
                errors++;
                $display("FAIL single_byte%0d: v=%b data=%h done=%b, required 1 %h 0", b, out_valid, out_data, done, eb[b]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done: done=%b err=%b v=%b busy=%b, required 1 0 0 1", done, err, out_valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_bank_cross();
        ovr[32'h0000_FFFF] = 32'hA0A1_A2A3;
        ovr[32'h0001_0000] = 32'hB0B1_B2B3;
        run_xfer(32'h0000_FFFF, 2, 1'b0);
        checks++;
        if (!stream_ok() || got_q.size() != 8 || got_q[7] !== 8'hB0) begin
            errors++;
            $display("FAIL bank_stream: got %0d bytes, required 8 bytes A3..A0 B3..B0", got_q.size());
        end
        checks++;
        if (addr_q.size() != 2 || addr_q[0] !== 32'h0000_FFFF || addr_q[1] !== 32'h0001_0000) begin
            errors++;
            $display("FAIL bank_addrs: got %0d reads, required 2 reads 0000ffff,00010000", addr_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL bank_done: done=%0d err=%0d, required 1 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        ovr[32'h200] = 32'hDEAD_BEEF;
        build_exp(32'h200, 1);
        clear_mon();
        base_addr = 32'h200; word_count = 1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hEF) begin
            errors++;
            $display("FAIL bp_byte0: v=%b data=%h, required 1 ef", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hBE) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b data=%h, required 1 be", i, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hBE) begin
            errors++;
            $display("FAIL bp_release: v=%b data=%h, required 1 be", out_valid, out_data);
        end
        wait_done(20);
        checks++;
        if (!stream_ok() || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_stream: got %0d bytes done=%0d, required ef be ad de with 1 done", got_q.size(), done_cnt);
        end
    endtask

    task automatic test_error();
        run_xfer(32'h0003_FFFF, 3, 1'b0);
        checks++;
        if (!stream_ok() || got_q.size() != 4) begin
            errors++;
            $display("FAIL err_stream: got %0d bytes, required 4", got_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 1 || err_lone != 0) begin
            errors++;
            $display("FAIL err_pulse: done=%0d err=%0d lone=%0d, required 1 1 0", done_cnt, err_cnt, err_lone);
        end
        checks++;
        if (addr_q.size() != 1 || addr_q[0] !== 32'h0003_FFFF) begin
            errors++;
            $display("FAIL err_reads: got %0d reads, required 1 read at 0003ffff", addr_q.size());
        end
    endtask

    task automatic test_zero_and_ignore();
        clear_mon();
        base_addr = 32'h40; word_count = 0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b err=%b v=%b busy=%b, required 1 0 0 1", done, err, out_valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL zero_idle: done=%b busy=%b bytes=%0d, required 0 0 0", done, busy, got_q.size());
        end
        build_exp(32'h1230, 2);
        clear_mon();
        base_addr = 32'h1230; word_count = 2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        base_addr = 32'h7777; word_count = 9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        checks++;
        if (!stream_ok() || done_cnt != 1 || addr_q.size() != 2 || addr_q[1] !== 32'h1231) begin
            errors++;
            $display("FAIL ignore_start: bytes=%0d done=%0d reads=%0d, required 8 1 2", got_q.size(), done_cnt, addr_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int n;
        clear_mon();
        base_addr = 32'h500; word_count = 4; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({mem_re, mem_addr, out_data, out_valid, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: re=%b addr=%h data=%h v=%b busy=%b done=%b, required all 0",
                     mem_re, mem_addr, out_data, out_valid, busy, done);
        end
        rst = 1'b0;
        clear_mon();
        repeat (20) tick();
        checks++;
        if (done_cnt != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet: done=%0d bytes=%0d, required 0 0", done_cnt, got_q.size());
        end
        run_xfer(32'h600, 2, 1'b0);
        checks++;
        if (!stream_ok() || done_cnt != 1) begin
            errors++;
            $display("FAIL midrst_restart: bytes=%0d done=%0d, required 8 1", got_q.size(), done_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] base;
        int cnt;
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 2))
                0:       base = 32'($urandom_range(0, 32'h3FFFF));
                1:       base = 32'h0000_FFFC + 32'($urandom_range(0, 5));
                default: base = 32'h0003_FFFC + 32'($urandom_range(0, 6));
            endcase
            cnt = $urandom_range(1, 5);
            run_xfer(base, cnt, 1'b1);
            checks++;
            if (!stream_ok() || done_cnt != 1 || err_cnt != int'(exp_err) || err_lone != 0) begin
                errors++;
                $display("FAIL random%0d base=%h cnt=%0d: bytes=%0d done=%0d err=%0d, required bytes=%0d done=1 err=%0d",
                         t, base, cnt, got_q.size(), done_cnt, err_cnt, exp_q.size(), exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bank_cross();
        test_backpressure();
        test_error();
        test_zero_and_ignore();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
